// File: rtl/multiport_register_file_if.sv
// rtl/multiport_register_file_if.sv - read/write port bundle for multiport_register_file
interface multiport_register_file_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [1:0]            wr_en;
  logic [2*AW-1:0]       wr_addr;
  logic [2*XLEN-1:0]     wr_data;
  logic                  ready;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, ready
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, ready
  );
endinterface

// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - parametrised register file, sequential clear, optional bypass (REGFILE_BYPASS_EN)
module multiport_register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
) (
  input logic                    clk,
  input logic                    rst,
  multiport_register_file_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  logic [AW-1:0]         cnt;
  logic                  ready_q;
  logic [XLEN-1:0]       mem [NREGS];
  logic [NREAD*XLEN-1:0] rd_c;
  logic [AW-1:0]         ra [NREAD];
  logic [XLEN-1:0]       rv [NREAD];

  logic [AW-1:0]   wa0, wa1;
  logic [XLEN-1:0] wd0, wd1;

  assign wa0 = bus.wr_addr[0 +: AW];
  assign wa1 = bus.wr_addr[AW +: AW];
  assign wd0 = bus.wr_data[0 +: XLEN];
  assign wd1 = bus.wr_data[XLEN +: XLEN];

  // Clear/run sequencer: counter walks entries 1..NREGS-1, ready registered on the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      cnt     <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (cnt == LAST) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: begin
          state   <= RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Storage: clear walk in CLEAR, prioritised writes in RUN (port 1 assigned last so it wins);
  // entry 0 is never written, reads mask it instead
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else begin
        if (bus.wr_en[0] && wa0 != '0) mem[wa0] <= wd0;
        if (bus.wr_en[1] && wa1 != '0) mem[wa1] <= wd1;
      end
    end
  end

  // Combinational read ports; zero while not ready or for address 0
  always_comb begin
    rd_c = '0;
    for (int i = 0; i < NREAD; i++) begin
      ra[i] = bus.rd_addr[i*AW +: AW];
      rv[i] = mem[ra[i]];
`ifdef REGFILE_BYPASS_EN
      if (ready_q) begin
        if (bus.wr_en[0] && wa0 != '0 && wa0 == ra[i]) rv[i] = wd0;
        if (bus.wr_en[1] && wa1 != '0 && wa1 == ra[i]) rv[i] = wd1;
      end
`endif
      if (!ready_q || ra[i] == '0) rv[i] = '0;
      rd_c[i*XLEN +: XLEN] = rv[i];
    end
  end

  assign bus.rd_data = rd_c;
  assign bus.ready   = ready_q;
endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised integer register file that replaces the fixed 32×32, 2-read/1-write file in the decode stage. It has configurable data width, register count and read-port count, plus two prioritised write ports for writeback and a future second issue slot. Instead of flopping every entry to zero in one cycle, a sequential clear engine walks the array after reset, so the block maps onto SRAM-style storage. An optional write-to-read bypass is compiled in by macro.

## Interface
- XLEN, 32, data width in bits (≥8)
- NREGS, 32, number of architectural registers; power of two, 4..64
- NREAD, 2, number of read ports, 1..4
- AW, $clog2(NREGS), address width (derived, not overridden)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- rd_addr  input  NREAD*AW  packed read addresses; port i at [i*AW +: AW]
- rd_data  output  NREAD*XLEN  packed read data; port i at [i*XLEN +: XLEN]
- wr_en  input  2  write enables; bit k belongs to write port k
- wr_addr  input  2*AW  packed write addresses
- wr_data  input  2*XLEN  packed write data
- ready  output  1  high when clear is complete and writes are accepted

## Operation
- States: CLEAR and RUN.
- rst=1 at an edge:
  - state ← CLEAR, clear counter ← 1, ready ← 0.
  - Array contents are not touched at that edge.
- CLEAR:
  - Each edge with rst=0 writes zero to entry[counter], then counter increments.
  - When the edge writes entry NREGS-1, state ← RUN and ready ← 1.
  - The clear therefore takes NREGS-1 edges after rst falls.
  - wr_en is ignored in this state.
- RUN: at each edge, write port k stores wr_data[k] into entry wr_addr[k] when wr_en[k]=1 and wr_addr[k]≠0.
- Both write ports, same address, same edge: port 1 wins.
- Entry 0:
  - Never written.
  - Reads of address 0 return 0 on every port, in every state.
- Reads:
  - Combinational and independent per port.
  - Any combination of equal or different addresses is legal.
- rd_data is 0 on all ports while ready=0, regardless of rd_addr.
- Reset mid-CLEAR or mid-RUN: the counter restarts at 1 and ready drops on the same edge. Array contents written before that edge are unspecified until the new clear finishes.
- No out-of-range addresses exist: NREGS is a power of two.

## Timing
- Write latency: data written at edge N is visible on rd_data combinationally after edge N.
- Read latency: zero cycles (combinational from rd_addr).
- ready:
  - 0 during reset.
  - Rises at the edge that clears entry NREGS-1, which is edge NREGS-1 after rst deasserts.
- Output reset values: ready=0, rd_data=0 on all ports.
- No handshake on writes. The producer must hold off until ready=1, because writes in CLEAR are dropped silently.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In RUN, a read whose address equals an enabled, non-zero write address in the same cycle returns that wr_data combinationally.
  - If both write ports match, the port 1 value is returned.
  - This is for decode reading a register that writeback is writing in the same cycle.
- REGFILE_BYPASS_EN undefined:
  - No forwarding; reads return the pre-edge array value.
  - No combinational path from wr_* to rd_data.

## Test plan
- Reset and clear: NREGS=32. Hold rst 2 cycles, release, sample ready each cycle.
  - Expect ready=0 for 30 edges and ready=1 after the 31st.
  - After clear, reading every address returns 0.
- Basic write/read: in RUN, write port 0 stores x1=32'hDEADBEEF and write port 1 stores x2=32'h12345678 at the same edge. Next cycle, read x1 and x2 on ports 0 and 1.
  - Expect 32'hDEADBEEF and 32'h12345678.
  - Set both read ports to address 2: both return 32'h12345678.
- x0 and write collision:
  - Write 32'hFFFFFFFF to x0 on both ports; reading address 0 returns 0.
  - Port 0 writes x5=32'hAAAA0000 and port 1 writes x5=32'h5555FFFF at the same edge; x5 reads 32'h5555FFFF.
- Writes during CLEAR: during CLEAR, assert wr_en[0] with x3=32'hCAFEF00D.
  - rd_data=0 while ready=0.
  - After ready=1, x3 reads 0.
- Bypass: x4 holds 32'h11111111. Drive wr_en[0]=1, x4=32'h22222222, rd_addr port 0 = 4 in the same cycle, and sample before the edge.
  - With REGFILE_BYPASS_EN: expect 32'h22222222.
  - Without it: expect 32'h11111111.
  - After the edge, both builds read 32'h22222222.
- Reset mid-operation:
  - Assert rst for 1 cycle at clear counter 10: ready stays 0 for a fresh 31 edges.
  - Write x7=32'h0BADBEEF in RUN, then pulse rst: after the new clear, x7 reads 0.
